// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing constants, token codes and glyph geometry.
package vga_pkg;
  localparam int H_VIS = 640, H_FP = 16, H_SYNC = 96, H_BP = 48;
  localparam int V_VIS = 480, V_FP = 10, V_SYNC = 2, V_BP = 33;
  localparam int GLYPH_W = 8, GLYPH_H = 16;
  localparam logic [3:0] TOK_PLUS = 4'ha, TOK_MINUS = 4'hb, TOK_MUL = 4'hc;
  localparam logic [3:0] TOK_DIV = 4'hd, TOK_EQ = 4'he, TOK_BLANK = 4'hf;
endpackage

// File: rtl/glyph_rom.sv
// glyph_rom: 16 glyphs x 16 rows x 8 bits, addressed by {token, row}, registered output.
// Glyph art occupies rows 4..11; the other rows and the blank token are all zero.
module glyph_rom
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] addr_i,
  output logic [7:0] data_o
);
  logic [63:0] g;
  logic [3:0]  r;
  logic [7:0]  data_d;
  always_comb begin
    case (addr_i[7:4])
      4'h0:      g = 64'h3C666E7666663C00;
      4'h1:      g = 64'h1838181818187E00;
      4'h2:      g = 64'h3C66060C30607E00;
      4'h3:      g = 64'h3C66061C06663C00;
      4'h4:      g = 64'h0C1C3C6C7E0C0C00;
      4'h5:      g = 64'h7E607C0606663C00;
      4'h6:      g = 64'h3C607C6666663C00;
      4'h7:      g = 64'h7E060C1818181800;
      4'h8:      g = 64'h3C66663C66663C00;
      4'h9:      g = 64'h3C66663E060C3800;
      TOK_PLUS:  g = 64'h0018187E18180000;
      TOK_MINUS: g = 64'h0000007E00000000;
      TOK_MUL:   g = 64'h00663CFF3C660000;
      TOK_DIV:   g = 64'h02060C1830604000;
      TOK_EQ:    g = 64'h00007E007E000000;
      default:   g = '0;
    endcase
    r = addr_i[3:0];
    data_d = (r >= 4'd4 && r < 4'd12) ? g[{~3'(r - 4'd4), 3'b000} +: 8] : 8'h00;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) data_o <= 8'h00;
    else data_o <= data_d;
endmodule

// File: rtl/vga_token_renderer.sv
// vga_token_renderer: scans a 96-token calculator buffer out as a VGA text line.
// Pipeline: S0 counters, S1 token/region/sync, S2 glyph byte and sync outputs.
module vga_token_renderer
  import vga_pkg::*;
#(
  parameter int         X0       = 128,
  parameter int         Y0       = 224,
  parameter int         COLS     = 48,
  parameter logic [7:0] FG_COLOR = 8'hFF,
  parameter logic [7:0] BG_COLOR = 8'h00,
  parameter int         H_ACTIVE = H_VIS,
  parameter int         V_ACTIVE = V_VIS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [0:383] buffer,
  output logic         vga_hs,
  output logic         vga_vs,
  output logic [7:0]   rgb,
  output logic         frame_start
);
  // Visible size is overridable; porch and sync widths stay fixed.
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_ON = 10'(H_ACTIVE + H_FP), HS_OFF = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_ON = 10'(V_ACTIVE + V_FP), VS_OFF = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] HV = 10'(H_ACTIVE), VV = 10'(V_ACTIVE);
  localparam logic [9:0] XL = 10'(X0), XR = 10'(X0 + GLYPH_W * COLS);
  localparam logic [9:0] YT = 10'(Y0), YB = 10'(Y0 + 2 * GLYPH_H);
  logic [9:0]   h_q, h_d, v_q, v_d, hr;
  logic [4:0]   vr;
  logic [6:0]   idx;
  logic         in_reg;
  logic [0:383] snap_q;
  logic [3:0]   tok1_q, grow1_q;
  logic [2:0]   gcol1_q, gcol2_q;
  logic         reg1_q, vis1_q, hs1_q, vs1_q, reg2_q;
  logic [7:0]   glyph;
  always_comb begin
    h_d = (h_q == H_LAST) ? '0 : h_q + 10'd1;
    v_d = (h_q != H_LAST) ? v_q : (v_q == V_LAST) ? '0 : v_q + 10'd1;
    hr = h_q - XL;
    vr = 5'(v_q - YT);
    idx = (vr[4] ? 7'(COLS) : 7'd0) + hr[9:3];
    in_reg = h_q >= XL && h_q < XR && v_q >= YT && v_q < YB;
    frame_start = h_q == 10'd0 && v_q == VV;
    rgb = reg2_q ? (glyph[3'd7 - gcol2_q] ? FG_COLOR : BG_COLOR) : 8'h00;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= '0;
      v_q <= '0;
      snap_q <= '1;
      tok1_q <= '0;
      grow1_q <= '0;
      gcol1_q <= '0;
      gcol2_q <= '0;
      reg1_q <= 1'b0;
      vis1_q <= 1'b0;
      reg2_q <= 1'b0;
      hs1_q <= 1'b1;
      vs1_q <= 1'b1;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
      if (frame_start) snap_q <= buffer;
      tok1_q <= snap_q[9'(380) - {idx, 2'b00} +: 4];
      grow1_q <= vr[3:0];
      gcol1_q <= hr[2:0];
      reg1_q <= in_reg;
      vis1_q <= h_q < HV && v_q < VV;
      hs1_q <= !(h_q >= HS_ON && h_q < HS_OFF);
      vs1_q <= !(v_q >= VS_ON && v_q < VS_OFF);
      gcol2_q <= gcol1_q;
      reg2_q <= reg1_q & vis1_q;
      vga_hs <= hs1_q;
      vga_vs <= vs1_q;
    end
  end
  glyph_rom u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .addr_i({tok1_q, grow1_q}),
    .data_o(glyph)
  );
endmodule

// File: tb/tb_vga_token_renderer.sv
// tb_vga_token_renderer: scoreboard bench on a shrunken raster (narrow region, short visible area).
module tb_vga_token_renderer;
  localparam int X0 = 4, Y0 = 2, COLS = 16, HA = 136, VA = 36;
  localparam int HT = HA + 160, VT = VA + 45;
  localparam logic [7:0] FG = 8'hE3, BG = 8'h25;
  typedef struct {int h; int v; logic [9:0] o;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [0:383] buffer = '1, msnap = '1, buf_a, buf_b;
  logic vga_hs, vga_vs, frame_start;
  logic [7:0] rgb;
  exp_t q[$];
  exp_t e;
  int total = 0, bad = 0;
  int mh = 0, mv = 0, mf = 0, cyc = 0, hs_run = 0, vs_run = 0, last_fs = -1, first_fall = -1;
  logic fs_exp;
  vga_token_renderer #(.X0(X0), .Y0(Y0), .COLS(COLS), .FG_COLOR(FG), .BG_COLOR(BG),
                       .H_ACTIVE(HA), .V_ACTIVE(VA)) dut (
    .clk(clk), .rst_n(rst_n), .buffer(buffer), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .rgb(rgb), .frame_start(frame_start));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] font_of(input logic [3:0] t);
    case (t)
      4'h0: return 64'h3C666E7666663C00;
      4'h1: return 64'h1838181818187E00;
      4'h2: return 64'h3C66060C30607E00;
      4'h3: return 64'h3C66061C06663C00;
      4'h4: return 64'h0C1C3C6C7E0C0C00;
      4'h5: return 64'h7E607C0606663C00;
      4'h6: return 64'h3C607C6666663C00;
      4'h7: return 64'h7E060C1818181800;
      4'h8: return 64'h3C66663C66663C00;
      4'h9: return 64'h3C66663E060C3800;
      4'ha: return 64'h0018187E18180000;
      4'hb: return 64'h0000007E00000000;
      4'hc: return 64'h00663CFF3C660000;
      4'hd: return 64'h02060C1830604000;
      4'he: return 64'h00007E007E000000;
      default: return 64'h0;
    endcase
  endfunction
  function automatic exp_t model_px(input int h, input int v);
    exp_t x;
    logic [63:0] g;
    logic [3:0] t;
    int k, gr, gc;
    x.h = h;
    x.v = v;
    x.o[9] = !(h >= HA + 16 && h < HA + 112);
    x.o[8] = !(v >= VA + 10 && v < VA + 12);
    x.o[7:0] = 8'h00;
    if (h < HA && v < VA && h >= X0 && h < X0 + 8 * COLS && v >= Y0 && v < Y0 + 32) begin
      k = ((v - Y0) / 16) * COLS + (h - X0) / 8;
      gr = (v - Y0) % 16;
      gc = (h - X0) % 8;
      t = msnap[380 - 4 * k +: 4];
      g = font_of(t);
      x.o[7:0] = (gr >= 4 && gr < 12 && g[63 - 8 * (gr - 4) - gc]) ? FG : BG;
    end
    return x;
  endfunction
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      e.h = -1;
      e.v = -1;
      e.o = 10'h300;
      q.push_back(e);
      q.push_back(e);
      mh = 0; mv = 0; mf = 0; cyc = 0; hs_run = 0; vs_run = 0; last_fs = -1; first_fall = -1;
      msnap = '1;
    end else begin
      q.push_back(model_px(mh, mv));
      e = q.pop_front();
      check($sformatf("pixel h=%0d v=%0d frame=%0d", e.h, e.v, mf), {22'd0, vga_hs, vga_vs, rgb}, {22'd0, e.o});
      fs_exp = mh == 0 && mv == VA;
      check("frame_start", {31'd0, frame_start}, {31'd0, fs_exp});
      if (fs_exp) begin
        if (last_fs >= 0) check("frame_period", cyc - last_fs, HT * VT);
        last_fs = cyc;
        msnap = buffer;
      end
      if (!vga_hs) begin
        if (first_fall < 0) begin
          first_fall = cyc;
          check("first_hs_fall", cyc, HA + 16 + 2);
        end
        hs_run++;
      end else begin
        if (hs_run > 0) check("hs_low_len", hs_run, 96);
        hs_run = 0;
      end
      if (!vga_vs) vs_run++;
      else begin
        if (vs_run > 0) check("vs_low_len", vs_run, 2 * HT);
        vs_run = 0;
      end
      if (mh == HT - 1) begin
        mh = 0;
        if (mv == VT - 1) begin mv = 0; mf++; end
        else mv++;
      end else mh++;
      cyc++;
    end
  end
  initial begin
    #(10 * 80000);
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    buf_a = '1;
    for (int k = 0; k < 2 * COLS; k++) buf_a[380 - 4 * k +: 4] = 4'(k % 16);
    buf_a[380 +: 4] = 4'h7;
    buf_a[380 - 4 * (COLS - 1) +: 4] = 4'hb;
    buf_a[380 - 4 * COLS +: 4] = 4'he;
    buf_a[380 - 4 * 30 +: 4] = 4'h0;
    buf_b = buf_a;
    buf_b[380 +: 4] = 4'h3;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    while (cyc < 496) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("async_reset", {21'd0, vga_hs, vga_vs, rgb, frame_start}, 32'h600);
    repeat (3) @(posedge clk);
    #2 buffer = buf_a;
    rst_n = 1'b1;
    while (!(mf == 1 && mv == Y0 + 8)) @(posedge clk);
    #2 buffer = buf_b;
    while (!(mf == 2 && mv == Y0 + 16)) @(posedge clk);
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_token_renderer.md
# vga_token_renderer

Reads the 384-bit calculator token buffer (96 four-bit tokens) and scans it out as a 640x480@60 VGA text line. The buffer writer fills tokens upstream; this block is the display-side reader. Each token maps to an 8x16 glyph. The buffer is snapshotted once per frame so the picture never tears.

## Interface
Parameters:
- X0, 128: left pixel of text region
- Y0, 224: top line of text region
- COLS, 48: tokens per text row (2 rows, 96 tokens)
- FG_COLOR, 8'hFF: glyph pixel colour (RGB 3:3:2)
- BG_COLOR, 8'h00: text-region background colour

Ports:
- clk  in  1  25 MHz pixel clock; the only clock
- rst_n  in  1  reset, asynchronous, active-low
- buffer  in  [0:383]  token buffer; token k = buffer[380-4k +: 4], buffer[380-4k] is its MSB; all-ones = empty
- vga_hs  out  1  horizontal sync, active-low
- vga_vs  out  1  vertical sync, active-low
- rgb  out  8  pixel colour, 3:3:2
- frame_start  out  1  one-cycle pulse when the snapshot loads

## Operation
- Token codes: 0-9 are digits, a '+', b '-', c '*', d '/', e '=', f blank (renders BG_COLOR).
- h counter 0..799, v counter 0..524. h wraps 799->0 and increments v. v wraps 524->0.
- Visible area: h<640, v<480. H: front porch 640-655, sync 656-751, back porch 752-799. V: front porch 480-489, sync 490-491, back porch 492-524.
- Snapshot: at h==0 and v==480, snap <= buffer and frame_start=1 for that cycle. Changes to buffer at any other time are not displayed until the next load.
- Text region: X0<=h<X0+8*COLS and Y0<=v<Y0+32.
  - col=(h-X0)>>3, row=(v-Y0)>>4, idx=row*COLS+col (0..95).
  - glyph row = (v-Y0)&15, glyph column = (h-X0)&7; column 0 is the glyph byte MSB.
- Pixel: glyph bit 1 -> FG_COLOR; glyph bit 0 or blank token -> BG_COLOR. Outside the text region but visible -> 8'h00. Blanking -> 8'h00.

## Timing
- 3-stage pipeline.
  - S0: h/v counters.
  - S1: register token (from snap), glyph row, column, region flag, visible flag, hs, vs.
  - S2: glyph ROM output registered; rgb/vga_hs/vga_vs registered.
- Output latency is 2 cycles from counter value to rgb. Sync signals are delayed identically, so rgb, vga_hs and vga_vs always refer to the same (h,v).
- vga_hs is low for exactly 96 consecutive cycles per 800-cycle line. vga_vs is low for exactly 2 lines (1600 cycles) per 525-line frame.
- Reset (async assert, any time including mid-frame): h=v=0, snap = all ones, all pipeline registers cleared, vga_hs=1, vga_vs=1, rgb=0, frame_start=0. After release, counting restarts at h=v=0. The first frame shows blank until the first snapshot at v==480.
- If snapshot load and a region pixel coincide, the old snap is used for that pixel; this cannot occur with default parameters.
- idx>95 cannot occur with 2 rows; no bounds logic beyond the region flag.

## Structure
- Shared package `vga_pkg`: timing constants (H_VIS, H_FP, H_SYNC, H_BP, V_*), token code localparams (TOK_PLUS=4'ha, TOK_MINUS, TOK_MUL, TOK_DIV, TOK_EQ, TOK_BLANK=4'hf), glyph dimensions.
- Sub-module `glyph_rom`: 16 glyphs x 16 rows x 8 bits, addressed by {token, row}, registered output (this is pipeline stage S2's ROM register). It is also reusable by future display blocks.

## Test plan
- Reset: hold rst_n=0 mid-frame -> vga_hs=1, vga_vs=1, rgb=0, frame_start=0 immediately. After release, the first vga_hs falling edge appears at cycle 656+2.
- Sync counts: run 2 frames -> vga_hs low 96 of every 800 cycles, vga_vs low 1600 of every 420000 cycles, frame_start period 420000.
- Blank buffer: buffer all ones -> every visible pixel is rgb 8'h00 for the whole frame.
- Single digit: token 0 = 4'h1 (buffer[380:383]=4'b0001), rest f. After a snapshot, pixels x=128..135, y=224..239 match glyph '1' rows bit-for-bit in FG/BG. Pixel x=136 is BG.
- Second-row addressing: token 48 = 4'he -> '=' glyph at x=128..135, y=240..255; token 47 = 4'hb -> '-' at x=504..511, y=224..239.
- Snapshot isolation: load token 0 = 4'h7, then at v=300 change it to 4'h3 -> the rest of that frame shows '7', and the next frame shows '3'.
